// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
// Contents: FSM state enum, frame byte-count constants, cpu_hold reset value.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHECK state).
package imem_loader_pkg;

  localparam int   CNT_BYTES    = 2;     // word-count header bytes
  localparam int   WORD_BYTES   = 4;     // bytes per instruction word
  localparam logic CPU_HOLD_RST = 1'b0;  // CPU runs existing RAM after reset

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_ERR    = 3'd5,
    ST_CHECK  = 3'd6
`else
    ST_ERR    = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/imem_loader_timer.sv
// rtl/imem_loader_timer.sv - inter-byte idle timeout counter
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clr          zero the counter (takes priority over en)
//   en           count one idle cycle
//   expired      this cycle's increment reaches TIMEOUT_CYCLES
module loader_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_WIDTH       = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_WIDTH-1:0] LAST_CNT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] count_q;
  logic [TO_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TO_WIDTH'(1);
    end
  end

  // Flags the cycle whose increment would make the count reach the limit,
  // so the owner can move to its error state on that same edge.
  assign expired = en && !clr && (count_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial boot loader writing big-endian words into instruction RAM
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start               pulse, opens (or restarts) a load frame
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   wr_en/addr/data     instruction RAM write port (byte address, word aligned)
//   cpu_hold            high while the CPU must stay in reset
//   done, error         outcome of the last frame
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_WIDTH       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = 8 * CNT_BYTES;
  // Largest accepted word count: the full RAM depth.
  localparam logic [CNT_W:0] MAX_WORDS =
    {{(CNT_W - ADDR_WIDTH){1'b0}}, 1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e END_STATE = ST_CHECK;
`else
  localparam state_e END_STATE = ST_DONE;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           asm_q, asm_d;  // first three bytes of the word in flight
  logic                  wr_en_q, wr_en_d;
  logic [31:0]           wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic             loading;
  logic             timer_expired;
  logic [CNT_W-1:0] cnt_new;
  logic [CNT_W-1:0] word_num;

  assign loading = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!loading || rx_valid || start),
    .en     (loading),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    cnt_new    = {cnt_q[CNT_W-1:8], rx_data};
    word_num   = CNT_W'(word_idx_q) + CNT_W'(1);

    if (start) begin
      // Start wins over a same-cycle byte, which is dropped.
      state_d    = ST_CNT_HI;
      word_idx_d = '0;
      byte_idx_d = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d      = '0;
`endif
    end else if (timer_expired) begin
      state_d = ST_ERR;
      error_d = 1'b1;
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (rx_valid && loading) begin
        xor_d = xor_q ^ rx_data;
      end
`endif
      case (state_q)
        ST_CNT_HI: begin
          if (rx_valid) begin
            cnt_d[CNT_W-1:8] = rx_data;
            state_d          = ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (rx_valid) begin
            cnt_d = cnt_new;
            if ({1'b0, cnt_new} > MAX_WORDS) begin
              state_d = ST_ERR;
              error_d = 1'b1;
            end else if (cnt_new == '0) begin
              state_d = END_STATE;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            asm_d      = {asm_q[15:0], rx_data};
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
              wr_en_d    = 1'b1;
              wr_addr_d  = {{(30 - ADDR_WIDTH){1'b0}}, word_idx_q, 2'b00};
              wr_data_d  = {asm_q, rx_data};
              word_idx_d = word_idx_q + 1'b1;
              if (word_num == cnt_q) begin
                state_d = END_STATE;
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_valid) begin
            if (rx_data == xor_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ERR;
              error_d = 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          // Flags follow one cycle after entering DONE.
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= CPU_HOLD_RST;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  int          wr_cnt = 0;
  logic [31:0] addr_log [8];
  logic [31:0] data_log [8];
  logic [7:0]  frame_q [$];

  imem_loader #(
    .ADDR_WIDTH    (6),
    .TIMEOUT_CYCLES(100),
    .TO_WIDTH      (20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record RAM writes half a cycle after the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_cnt < 8) begin
        addr_log[wr_cnt] = wr_addr;
        data_log[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
  endtask

  task automatic send_trailer(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(b);
`else
    if (b === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic test_reset();
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    n_checks++; if (wr_addr !== 32'h0) begin n_errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
    n_checks++; if (wr_data !== 32'h0) begin n_errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL reset_cpu_hold got %b exp 0", cpu_hold); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error got %b exp 0", error); end
  endtask

  task automatic test_load_two();
    wr_cnt = 0;
    pulse_start();
    n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL load_hold got %b exp 1", cpu_hold); end
    frame_q = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h40};
    send_frame();
    n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL load_last_wr_en got %b exp 1", wr_en); end
    n_checks++; if (wr_addr !== 32'h4) begin n_errors++; $display("FAIL load_last_addr got %h exp 4", wr_addr); end
    n_checks++; if (wr_data !== 32'h20080040) begin n_errors++; $display("FAIL load_last_data got %h exp 20080040", wr_data); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL load_done_early got %b exp 0", done); end
    send_trailer(8'h61);
    tick();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL load_done got %b exp 1", done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL load_release got %b exp 0", cpu_hold); end
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL load_wr_en_hold got %b exp 0", wr_en); end
    n_checks++; if (wr_data !== 32'h20080040) begin n_errors++; $display("FAIL load_data_hold got %h exp 20080040", wr_data); end
    n_checks++; if (wr_cnt !== 2) begin n_errors++; $display("FAIL load_wr_count got %0d exp 2", wr_cnt); end
    n_checks++; if (addr_log[0] !== 32'h0) begin n_errors++; $display("FAIL load_addr0 got %h exp 0", addr_log[0]); end
    n_checks++; if (data_log[0] !== 32'h08000003) begin n_errors++; $display("FAIL load_data0 got %h exp 08000003", data_log[0]); end
    // Stray byte after DONE is ignored.
    send_byte(8'hFF);
    tick();
    n_checks++; if (done !== 1'b1 || wr_cnt !== 2) begin n_errors++; $display("FAIL stray_after_done done %b writes %0d exp 1 2", done, wr_cnt); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    wr_cnt = 0;
    pulse_start();
    frame_q = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h40, 8'h60};
    send_frame();
    tick();
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL csum_bad_error got %b exp 1", error); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL csum_bad_done got %b exp 0", done); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL csum_bad_hold got %b exp 1", cpu_hold); end
    n_checks++; if (wr_cnt !== 2) begin n_errors++; $display("FAIL csum_bad_writes got %0d exp 2", wr_cnt); end
  endtask
`endif

  task automatic test_zero_count();
    wr_cnt = 0;
    pulse_start();
    frame_q = '{8'h00, 8'h00};
    send_frame();
    send_trailer(8'h00);
    tick();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL zero_done got %b exp 1", done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL zero_hold got %b exp 0", cpu_hold); end
    n_checks++; if (wr_cnt !== 0) begin n_errors++; $display("FAIL zero_writes got %0d exp 0", wr_cnt); end
  endtask

  task automatic test_oversize();
    wr_cnt = 0;
    pulse_start();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL start_clears_done got %b exp 0", done); end
    frame_q = '{8'h00, 8'h41};
    send_frame();
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL oversize_error got %b exp 1", error); end
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame();
    tick();
    n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL oversize_hold got %b exp 1", cpu_hold); end
    n_checks++; if (wr_cnt !== 0) begin n_errors++; $display("FAIL oversize_writes got %0d exp 0", wr_cnt); end
  endtask

  task automatic test_timeout();
    wr_cnt = 0;
    pulse_start();
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL start_clears_error got %b exp 0", error); end
    frame_q = '{8'h00, 8'h01, 8'h08, 8'h00};
    send_frame();
    for (int i = 0; i < 99; i++) tick();
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL timeout_early got %b exp 0 at 99 cycles", error); end
    tick();
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL timeout_error got %b exp 1 at 100 cycles", error); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL timeout_hold got %b exp 1", cpu_hold); end
    n_checks++; if (wr_cnt !== 0) begin n_errors++; $display("FAIL timeout_writes got %0d exp 0", wr_cnt); end
  endtask

  task automatic test_restart();
    wr_cnt = 0;
    pulse_start();
    frame_q = '{8'h00, 8'h02, 8'h08, 8'h00};
    send_frame();
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    frame_q = '{8'h00, 8'h01, 8'hAC, 8'h08, 8'h00, 8'h00};
    send_frame();
    send_trailer(8'hA5);
    tick();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL restart_done got %b exp 1", done); end
    n_checks++; if (wr_cnt !== 1) begin n_errors++; $display("FAIL restart_writes got %0d exp 1", wr_cnt); end
    n_checks++; if (addr_log[0] !== 32'h0) begin n_errors++; $display("FAIL restart_addr got %h exp 0", addr_log[0]); end
    n_checks++; if (data_log[0] !== 32'hAC080000) begin n_errors++; $display("FAIL restart_data got %h exp AC080000", data_log[0]); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    frame_q = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03};
    send_frame();
    n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL arst_pre_wr_en got %b exp 1", wr_en); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL arst_wr_en got %b exp 0", wr_en); end
    n_checks++; if (wr_data !== 32'h0) begin n_errors++; $display("FAIL arst_wr_data got %h exp 0", wr_data); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL arst_hold got %b exp 0", cpu_hold); end
    n_checks++; if (done !== 1'b0 || error !== 1'b0) begin n_errors++; $display("FAIL arst_flags got %b%b exp 00", done, error); end
    tick();
    #2;
    reset = 1'b1;
    tick();
    wr_cnt = 0;
    frame_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame();
    tick();
    n_checks++; if (wr_cnt !== 0) begin n_errors++; $display("FAIL no_start_writes got %0d exp 0", wr_cnt); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL no_start_hold got %b exp 0", cpu_hold); end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #12;
    test_reset();
    reset = 1'b1;
    tick();
    test_load_two();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_zero_count();
    test_oversize();
    test_timeout();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Serial boot loader for the pipeline's instruction memory. It takes a framed byte stream from the UART receiver and assembles big-endian 32-bit instruction words. Each word is written into the instruction RAM write port, which replaces the fixed program store. While loading, the CPU is held in reset; it is released once a complete, valid image has been written.

Parameters:
ADDR_WIDTH, 6, word-index width; RAM depth 2^ADDR_WIDTH words (word index = byte addr[ADDR_WIDTH+1:2])
TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes while a frame is open
TO_WIDTH, 20, width of the inter-byte timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (low = reset)
start  in  1  one-cycle pulse; opens a new load frame
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
wr_en  out  1  instruction RAM write strobe
wr_addr  out  32  byte address, word aligned (bits [1:0]=0)
wr_data  out  32  instruction word
cpu_hold  out  1  high = keep CPU in reset
done  out  1  level; last frame loaded successfully
error  out  1  level; last frame aborted (size, timeout, checksum)

Behaviour:
- Frame format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then N×4 bytes with each word MSB first, then a checksum byte (optional feature only).
- States: IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERR.
- Reset values: state IDLE, all outputs 0, internal counters 0. cpu_hold=0, so the CPU runs the existing RAM contents after reset.
- IDLE / DONE / ERR + start → CNT_HI. Clears done, error, word index, byte index, and checksum. Sets cpu_hold=1.
- A start pulse in any loading state restarts the frame immediately: returns to CNT_HI and discards partial data. Words already written stay in RAM.
- If start and rx_valid arrive in the same cycle, start wins and the byte is dropped.
- CNT_HI → CNT_LO on rx_valid. CNT_LO on rx_valid:
  - N > 2^ADDR_WIDTH → ERR.
  - N = 0 → CHECK if checksum is enabled, else DONE.
  - Otherwise → DATA.
- DATA: bytes shift into a 32-bit assembly register, MSB first.
  - On the 4th byte's rx_valid, the next cycle has wr_en=1 for exactly one cycle, wr_addr = word_index<<2 (bits above ADDR_WIDTH+1 = 0), and wr_data = the assembled word. Latency is one cycle.
  - The word index then increments. After word N-1 → CHECK if checksum is enabled, else DONE.
  - wr_addr and wr_data hold their last value when wr_en=0.
- Timeout: in CNT_HI, CNT_LO, DATA, or CHECK, the counter resets on every rx_valid and increments otherwise. Reaching TIMEOUT_CYCLES → ERR.
  - The counter does not run in IDLE, DONE, or ERR.
- DONE: done=1, cpu_hold=0 from the cycle after entry. Stray rx_valid is ignored.
- ERR: error=1, cpu_hold stays 1; a partial image never runs. Exit only via start or reset.
- rx_valid outside the loading states is ignored.
- Asynchronous reset during loading: immediate return to IDLE, cpu_hold=0, wr_en=0. RAM contents are undefined and software must reload.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: a running XOR covers every frame byte, including CNT_HI and CNT_LO. After the final data byte, the FSM enters CHECK and waits for one byte. If it equals the running XOR → DONE, else → ERR.
- Not defined: the CHECK state and XOR register are not compiled. The last data word goes directly to DONE, and the frame has no trailing byte.

Decomposition:
- Package imem_loader_pkg: state enum, frame byte-count constants (CNT_BYTES=2, WORD_BYTES=4), reset value of cpu_hold.
- Sub-module loader_timer: TO_WIDTH counter with clear/enable inputs and an expired output. The FSM and datapath stay in imem_loader.

Test Plan:
- Load 2 words (checksum off): start, bytes 00 02 08 00 00 03 20 08 00 40 → wr_en pulses at addr 0x0 with 0x08000003 and at addr 0x4 with 0x20080040. done=1 and cpu_hold=0 one cycle after the last write.
- Same frame with checksum on, trailing byte 0x61 → done=1. Trailing byte 0x60 → error=1, cpu_hold=1, both words written.
- Oversize count: bytes 00 41 with ADDR_WIDTH=6 → ERR after CNT_LO, no wr_en, cpu_hold=1.
- Timeout: start, 00 01 08 00, then silence (TIMEOUT_CYCLES=100 in bench) → error=1 exactly 100 cycles after the last byte, no write.
- Restart mid-frame: start, 00 02 08 00, then start with rx_valid in the same cycle, then a full 1-word frame 00 01 AC 08 00 00 → single write 0xAC080000 at addr 0x0, done=1.
- Async reset mid-DATA → outputs 0 without waiting for a clock edge. After release, rx_valid bytes without start produce no writes.
